expand_sequencer: RTL
=====================

# expand_sequencer

Controller that feeds the Expand stage from a valid/ready coefficient stream and sequences the whole job. It issues correctly spaced single-cycle write pulses, generates addresses in direct mode, resets Expand's position counter before each expand job, and reports completion. It sits between the host/DMA coefficient stream and Expand, which in turn writes the two FFT BRAM banks.

## Interface
Parameters:
- LOGN, 13, log2 of ring dimension N; must match the Expand instance.
- DW, 2*`OVERALL_BITS, coefficient word width ({im, re}).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle job request; sampled only in IDLE.
- mode  in  1  sampled with start: 1 = expand job, 0 = direct job.
- abort  in  1  cancels the running job.
- busy  out  1  high from the cycle after an accepted start until the cycle after done.
- done  out  1  one-cycle pulse at job completion.
- in_valid  in  1  coefficient available.
- in_ready  out  1  sequencer accepts a coefficient this cycle.
- in_data  in  DW  coefficient.
- exp_rst  out  1  synchronous reset pulse to Expand's position counter.
- do_expand  out  1  to Expand.
- addr_from_sw  out  LOGN  to Expand.
- data_from_sw  out  DW  to Expand.
- wea_from_sw  out  1  to Expand; never high two consecutive cycles.

## Operation
- Reset values: busy=0, done=0, in_ready=0, exp_rst=0, do_expand=0, addr_from_sw=0, data_from_sw=0, wea_from_sw=0; state IDLE; element counter 0.
- All outputs except in_ready are registered. in_ready is a decode of state (FETCH only).
- Job length L: expand job 2^(LOGN-1) elements (each fills one entry in both banks); direct job 2^LOGN elements.
- States:
  - IDLE: outputs idle. start=1 → latch mode, CLR.
  - CLR (1 cycle): busy=1, do_expand=mode, exp_rst=mode. → FETCH.
  - FETCH: in_ready=1, wea_from_sw=0. in_valid=1 → register in_data into data_from_sw, go to ISSUE. Otherwise stay.
  - ISSUE (1 cycle): wea_from_sw=1; addr_from_sw = element counter in direct mode, 0 in expand mode. Counter increments at the end of the cycle. Counter reaches L → DRAIN. Otherwise → FETCH.
  - DRAIN (2 cycles, wea=0): lets Expand's registered counter update and the last bank write retire. → DONE.
  - DONE (1 cycle): done=1, busy=1. → IDLE. In IDLE, busy=0 and do_expand=0.
- Spacing rule: every ISSUE is followed by at least one cycle with wea_from_sw=0, which is guaranteed by the FETCH state. Expand detects writes on the rising edge and advances its counter two cycles later, so one element every 2 cycles is the maximum rate and is always safe.
- Counter width is LOGN+1. The counter clears on CLR. addr_from_sw uses its low LOGN bits and never wraps within a job.
- abort=1 in any non-IDLE state → IDLE next cycle. wea_from_sw, in_ready and exp_rst are 0 from that cycle on. No done pulse. Partial bank contents are undefined.
- start while not IDLE is ignored. start and abort high together in IDLE: abort wins, so no job starts.
- rst_n low at any time forces reset values asynchronously, including mid-job and mid-ISSUE. Expand state is then stale, and the next expand job's CLR resynchronises it.

## Timing
- start at cycle 0 → CLR at cycle 1 (exp_rst as above) → FETCH from cycle 2.
- Handshake in cycle k → wea_from_sw=1 in cycle k+1 with that data → in_ready=1 again in cycle k+2.
- With in_valid held high, the job takes 2 + 2L cycles through the final ISSUE, plus 2 DRAIN cycles. done is high in cycle 2L+4 after start.
- in_valid gaps stretch FETCH with no limit. No timeout.

## Test plan
- Direct job, LOGN=3, in_valid held high, data = index: 8 pulses on cycles 3,5,…,17; addr 0..7; do_expand=0; exp_rst never high; done pulse on cycle 20.
- Expand job, LOGN=3: exp_rst=1 on cycle 1 only; 4 wea pulses spaced 2 cycles with addr 0; done on cycle 12. A reference model of Expand sees pos sequence 1,3,9,27 mod 16 and all 8 bank entries written exactly once.
- Random in_valid stalls (50%) on a direct job: wea never high on 2 consecutive cycles; data order preserved; exactly 8 pulses; done after the last pulse plus 3 cycles.
- abort asserted in the cycle after the 3rd pulse: wea and in_ready go to 0 next cycle; no done; busy drops. A following start runs a full, correct job.
- rst_n pulsed low asynchronously mid-ISSUE: all outputs reach reset values immediately; start during busy is ignored (no counter restart); start+abort in IDLE does not start a job.

Source files
------------

// File: rtl/expand_sequencer.sv
// expand_sequencer: feeds the Expand stage from a valid/ready coefficient
// stream. Issues spaced single-cycle write pulses, generates direct-mode
// addresses, clears Expand's position counter before expand jobs and
// signals job completion.

`ifndef OVERALL_BITS
`define OVERALL_BITS 16
`endif

module expand_sequencer #(
  parameter int LOGN = 13,
  parameter int DW   = 2*`OVERALL_BITS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            mode,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  output logic            exp_rst,
  output logic            do_expand,
  output logic [LOGN-1:0] addr_from_sw,
  output logic [DW-1:0]   data_from_sw,
  output logic            wea_from_sw
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    FETCH = 3'd2,
    ISSUE = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Job lengths: an expand element fills one entry in each bank, so an
  // expand job needs half as many elements as a direct job.
  localparam logic [LOGN:0] LEN_DIRECT = {1'b1, {LOGN{1'b0}}};
  localparam logic [LOGN:0] LEN_EXPAND = {2'b01, {(LOGN-1){1'b0}}};

  state_t          state;
  logic            mode_reg;
  logic [LOGN:0]   cnt;
  logic            drain_cnt;
  logic [LOGN:0]   cnt_inc;
  logic [LOGN:0]   job_len;

  assign cnt_inc  = cnt + (LOGN+1)'(1);
  assign job_len  = mode_reg ? LEN_EXPAND : LEN_DIRECT;

  // Ready is a pure state decode so a handshake always lands in FETCH,
  // which also guarantees an idle cycle between consecutive write pulses.
  assign in_ready = (state == FETCH);

  // Job sequencing FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mode_reg     <= 1'b0;
      cnt          <= '0;
      drain_cnt    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      exp_rst      <= 1'b0;
      do_expand    <= 1'b0;
      addr_from_sw <= '0;
      data_from_sw <= '0;
      wea_from_sw  <= 1'b0;
    end else if (abort && state != IDLE) begin
      // Cancel: drop everything that could touch Expand, no done pulse.
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      exp_rst     <= 1'b0;
      do_expand   <= 1'b0;
      wea_from_sw <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          busy        <= 1'b0;
          done        <= 1'b0;
          exp_rst     <= 1'b0;
          do_expand   <= 1'b0;
          wea_from_sw <= 1'b0;
          // abort in IDLE suppresses a simultaneous start
          if (start && !abort) begin
            mode_reg  <= mode;
            state     <= CLR;
            busy      <= 1'b1;
            do_expand <= mode;
            exp_rst   <= mode;
          end
        end
        CLR: begin
          exp_rst <= 1'b0;
          cnt     <= '0;
          state   <= FETCH;
        end
        FETCH: begin
          if (in_valid) begin
            data_from_sw <= in_data;
            addr_from_sw <= mode_reg ? '0 : cnt[LOGN-1:0];
            wea_from_sw  <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          wea_from_sw <= 1'b0;
          cnt         <= cnt_inc;
          if (cnt_inc == job_len) begin
            drain_cnt <= 1'b0;
            state     <= DRAIN;
          end else begin
            state <= FETCH;
          end
        end
        DRAIN: begin
          // Two quiet cycles so Expand's delayed counter and last write settle.
          if (drain_cnt) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          do_expand <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
